// File: rtl/cache_set.sv
// One set of a 2-way set-associative cache: valid/dirty/tag/4-word line per way, registered outputs, one-cycle ack.
// Define CACHE_SET_LRU_EN for LRU replacement; leave it undefined for round-robin replacement.
module cache_set #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5,
    parameter int WORD_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [0:WORD_W-1] word,
    input  logic              cmp,
    input  logic              write,
    input  logic [0:TAG_W-1]  tag,
    input  logic [0:DATA_W-1] data_in,
    input  logic              valid_in,
    output logic              hit,
    output logic              dirty,
    output logic [0:TAG_W-1]  tag_out,
    output logic [0:DATA_W-1] data_out,
    output logic              valid,
    output logic              ack
);
    localparam int WORDS = 2 ** WORD_W;

    logic [0:DATA_W-1] data_q [2][WORDS];
    logic [0:TAG_W-1]  tag_q  [2];
    logic [0:1]        valid_q, valid_d;
    logic [0:1]        dirty_q, dirty_d;
    logic              victim_q, victim_d;
`ifndef CACHE_SET_LRU_EN
    logic              fill_pend_q, fill_pend_d;
`endif

    logic              hit_q, hit_d;
    logic              dirty_out_q, dirty_out_d;
    logic              valid_out_q, valid_out_d;
    logic [0:TAG_W-1]  tag_out_q, tag_out_d;
    logic [0:DATA_W-1] data_out_q, data_out_d;
    logic              ack_q, ack_d;

    logic [0:1] match;
    logic       any_match;
    logic       hit_way;
    logic       cmp_victim;
    logic       sel_way;
    logic       fill_op;
    logic       cmp_wr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign match[gi] = valid_q[gi] && (tag_q[gi] == tag);
        end
    endgenerate

    always_comb begin
        any_match = |match;
        // Way 0 wins if both ways ever match.
        hit_way   = ~match[0];
`ifdef CACHE_SET_LRU_EN
        cmp_victim = victim_q;
`else
        // The first compare after a fill already sees the advanced victim, so the
        // freshly filled way is never reported as the eviction candidate.
        cmp_victim = victim_q ^ fill_pend_q;
`endif
        sel_way    = cmp ? (any_match ? hit_way : cmp_victim) : victim_q;
        fill_op    = enable && write && !cmp;
        cmp_wr_hit = enable && write && cmp && any_match;
    end

    always_comb begin
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        victim_d    = victim_q;
`ifndef CACHE_SET_LRU_EN
        fill_pend_d = fill_pend_q;
`endif
        hit_d       = hit_q;
        dirty_out_d = dirty_out_q;
        valid_out_d = valid_out_q;
        tag_out_d   = tag_out_q;
        data_out_d  = data_out_q;
        ack_d       = 1'b0;

        if (fill_op) begin
            valid_d[sel_way] = valid_in;
            dirty_d[sel_way] = 1'b0;
        end
        if (cmp_wr_hit) begin
            dirty_d[sel_way] = 1'b1;
        end

`ifdef CACHE_SET_LRU_EN
        if (enable && cmp && any_match) begin
            victim_d = ~hit_way;
        end
`else
        if (enable && cmp && fill_pend_q) begin
            victim_d    = ~victim_q;
            fill_pend_d = 1'b0;
        end
        if (fill_op) begin
            fill_pend_d = 1'b1;
        end
`endif

        // Outputs show post-write values of the selected way.
        if (enable) begin
            ack_d       = 1'b1;
            hit_d       = cmp && any_match;
            valid_out_d = valid_d[sel_way];
            dirty_out_d = dirty_d[sel_way];
            tag_out_d   = fill_op ? tag : tag_q[sel_way];
            data_out_d  = (fill_op || cmp_wr_hit) ? data_in : data_q[sel_way][word];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            victim_q    <= 1'b0;
`ifndef CACHE_SET_LRU_EN
            fill_pend_q <= 1'b0;
`endif
            hit_q       <= 1'b0;
            dirty_out_q <= 1'b0;
            valid_out_q <= 1'b0;
            tag_out_q   <= '0;
            data_out_q  <= '0;
            ack_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            victim_q    <= victim_d;
`ifndef CACHE_SET_LRU_EN
            fill_pend_q <= fill_pend_d;
`endif
            hit_q       <= hit_d;
            dirty_out_q <= dirty_out_d;
            valid_out_q <= valid_out_d;
            tag_out_q   <= tag_out_d;
            data_out_q  <= data_out_d;
            ack_q       <= ack_d;
            // Line and tag storage carry no reset value; writes are simply blocked during reset.
            if (fill_op || cmp_wr_hit) begin
                data_q[sel_way][word] <= data_in;
            end
            if (fill_op) begin
                tag_q[sel_way] <= tag;
            end
        end
    end

    assign hit      = hit_q;
    assign dirty    = dirty_out_q;
    assign valid    = valid_out_q;
    assign tag_out  = tag_out_q;
    assign data_out = data_out_q;
    assign ack      = ack_q;

endmodule

// File: tb/tb_cache_set.sv
// Scoreboard bench for cache_set: a reference model queues expected results per op; a monitor checks them on ack.
module tb_cache_set;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [0:1]  word;
    logic        cmp;
    logic        write;
    logic [0:4]  tag;
    logic [0:15] data_in;
    logic        valid_in;
    logic        hit;
    logic        dirty;
    logic [0:4]  tag_out;
    logic [0:15] data_out;
    logic        valid;
    logic        ack;

    typedef struct {
        logic        hit;
        logic        valid;
        logic        dirty;
        logic [0:4]  tag;
        logic [0:15] data;
        bit          tag_k;
        bit          data_k;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit          m_valid [2];
    bit          m_dirty [2];
    bit          m_tk    [2];
    logic [0:4]  m_tag   [2];
    logic [0:15] m_data  [2][4];
    bit          m_dk    [2][4];
    bit          m_victim;
    bit          m_fill;

    cache_set #(.DATA_W(16), .TAG_W(5), .WORD_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .word     (word),
        .cmp      (cmp),
        .write    (write),
        .tag      (tag),
        .data_in  (data_in),
        .valid_in (valid_in),
        .hit      (hit),
        .dirty    (dirty),
        .tag_out  (tag_out),
        .data_out (data_out),
        .valid    (valid),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_valid[w] = 1'b0;
            m_dirty[w] = 1'b0;
            m_tk[w]    = 1'b0;
            for (int k = 0; k < 4; k++) m_dk[w][k] = 1'b0;
        end
        m_victim = 1'b0;
        m_fill   = 1'b0;
    endtask

    task automatic model_op(input logic c, input logic w, input logic [0:1] wd,
                            input logic [0:4] t, input logic [0:15] d, input logic vi);
        exp_t e;
        bit   m0;
        bit   m1;
        bit   h;
        int   way;
        m0 = m_valid[0] && (m_tag[0] == t);
        m1 = m_valid[1] && (m_tag[1] == t);
        h  = c && (m0 || m1);
`ifdef CACHE_SET_LRU_EN
        way = h ? (m0 ? 0 : 1) : int'(m_victim);
        if (h) m_victim = (way == 0);
`else
        if (c && m_fill) begin
            m_victim = !m_victim;
            m_fill   = 1'b0;
        end
        way = h ? (m0 ? 0 : 1) : int'(m_victim);
        if (!c && w) m_fill = 1'b1;
`endif
        if (w && c && h) begin
            m_data[way][wd] = d;
            m_dk[way][wd]   = 1'b1;
            m_dirty[way]    = 1'b1;
        end else if (w && !c) begin
            m_data[way][wd] = d;
            m_dk[way][wd]   = 1'b1;
            m_tag[way]      = t;
            m_tk[way]       = 1'b1;
            m_valid[way]    = vi;
            m_dirty[way]    = 1'b0;
        end
        e.hit    = h;
        e.valid  = m_valid[way];
        e.dirty  = m_dirty[way];
        e.tag    = m_tag[way];
        e.data   = m_data[way][wd];
        e.tag_k  = m_tk[way];
        e.data_k = m_dk[way][wd];
        exp_q.push_back(e);
    endtask

    task automatic op(input logic c, input logic w, input logic [0:1] wd,
                      input logic [0:4] t, input logic [0:15] d, input logic vi);
        @(negedge clk);
        cmp      = c;
        write    = w;
        word     = wd;
        tag      = t;
        data_in  = d;
        valid_in = vi;
        enable   = 1'b1;
        model_op(c, w, wd, t, d, vi);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every acked op pops one expected result; no ack without a queued op.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_val("sb_ack", 32'(ack), 32'd1);
                check_val("sb_hit", 32'(hit), 32'(mon_e.hit));
                check_val("sb_valid", 32'(valid), 32'(mon_e.valid));
                check_val("sb_dirty", 32'(dirty), 32'(mon_e.dirty));
                if (mon_e.tag_k) check_val("sb_tag", 32'(tag_out), 32'(mon_e.tag));
                if (mon_e.data_k) check_val("sb_data", 32'(data_out), 32'(mon_e.data));
            end else begin
                check_val("ack_idle", 32'(ack), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; enable = 1'b0; cmp = 1'b0; write = 1'b0; word = 2'd0;
        tag = 5'd0; data_in = 16'd0; valid_in = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_hit", 32'(hit), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_dirty", 32'(dirty), 32'd0);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_tag", 32'(tag_out), 32'd0);
        check_val("rst_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;

        op(1'b1, 1'b0, 2'd0, 5'h03, 16'h0000, 1'b0); idle(1);
        check_val("rst_cmp_hit", 32'(hit), 32'd0);
        check_val("rst_cmp_valid", 32'(valid), 32'd0);

        // Fill then hit
        op(1'b0, 1'b1, 2'd3, 5'b11101, 16'h0F0F, 1'b1);
        op(1'b1, 1'b0, 2'd3, 5'b11101, 16'h0000, 1'b0); idle(1);
        check_val("fill_hit", 32'(hit), 32'd1);
        check_val("fill_data", 32'(data_out), 32'h0F0F);
        check_val("fill_tag", 32'(tag_out), 32'h1D);
        check_val("fill_valid", 32'(valid), 32'd1);
        check_val("fill_dirty", 32'(dirty), 32'd0);

        // Compare-write hit, then read back
        op(1'b1, 1'b1, 2'd3, 5'b11101, 16'hA5A5, 1'b0); idle(1);
        check_val("cw_hit", 32'(hit), 32'd1);
        check_val("cw_dirty", 32'(dirty), 32'd1);
        op(1'b1, 1'b0, 2'd3, 5'b11101, 16'h0000, 1'b0); idle(1);
        check_val("cw_readback", 32'(data_out), 32'hA5A5);

        // Fill with valid_in=0 never hits
        do_reset();
        op(1'b0, 1'b1, 2'd0, 5'h0A, 16'h1234, 1'b0);
        op(1'b1, 1'b0, 2'd0, 5'h0A, 16'h0000, 1'b0); idle(1);
        check_val("inv_hit", 32'(hit), 32'd0);
        check_val("inv_valid", 32'(valid), 32'd0);

        // Ways hold 01 (dirty) and 02; a miss reports way 0 as victim in both policies
        do_reset();
        op(1'b0, 1'b1, 2'd0, 5'h01, 16'h1111, 1'b1);
        op(1'b1, 1'b0, 2'd0, 5'h01, 16'h0000, 1'b0);
        op(1'b1, 1'b1, 2'd0, 5'h01, 16'h2222, 1'b0);
        op(1'b0, 1'b1, 2'd0, 5'h02, 16'h3333, 1'b1);
        op(1'b1, 1'b0, 2'd0, 5'h02, 16'h0000, 1'b0);
        op(1'b1, 1'b0, 2'd0, 5'h07, 16'h0000, 1'b0); idle(1);
        check_val("miss_hit", 32'(hit), 32'd0);
        check_val("miss_vtag", 32'(tag_out), 32'h01);
        check_val("miss_vdirty", 32'(dirty), 32'd1);
        check_val("miss_vdata", 32'(data_out), 32'h2222);
        op(1'b0, 1'b0, 2'd0, 5'h07, 16'h0000, 1'b0); idle(1);
        check_val("aread_tag", 32'(tag_out), 32'h01);
        check_val("aread_dirty", 32'(dirty), 32'd1);
        check_val("aread_hit", 32'(hit), 32'd0);

        // Enable low: outputs hold, ack stays low
        idle(3);
        check_val("hold_ack", 32'(ack), 32'd0);
        check_val("hold_tag", 32'(tag_out), 32'h01);
        check_val("hold_dirty", 32'(dirty), 32'd1);
        check_val("hold_data", 32'(data_out), 32'h2222);
        check_val("hold_valid", 32'(valid), 32'd1);

        // Asynchronous reset between edges clears outputs at once
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_valid", 32'(valid), 32'd0);
        check_val("arst_dirty", 32'(dirty), 32'd0);
        check_val("arst_tag", 32'(tag_out), 32'd0);
        check_val("arst_data", 32'(data_out), 32'd0);
        // An op requested while reset is held is dropped
        enable = 1'b1; cmp = 1'b0; write = 1'b1; word = 2'd0; tag = 5'h15;
        data_in = 16'hBEEF; valid_in = 1'b1;
        @(posedge clk);
        #1;
        check_val("arst_noack", 32'(ack), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        op(1'b1, 1'b0, 2'd0, 5'h15, 16'h0000, 1'b0); idle(1);
        check_val("arst_nofill", 32'(hit), 32'd0);

        // Random mix, narrow tag range to exercise hits, misses and replacement
        for (int i = 0; i < 400; i++) begin
            logic [0:1]  rw;
            logic [0:4]  rt;
            logic [0:15] rd;
            int          kind;
            kind = $urandom_range(0, 3);
            rw   = 2'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            rd   = 16'($urandom);
            op(kind[1], kind[0], rw, rt, rd, ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        check_val("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_set.md
Name: cache_set

Overview:
- One set of a 2-way set-associative cache.
- Each way holds a valid bit, a dirty bit, a 5-bit tag and a 4-word x 16-bit line.
- Serves the cache controller with four operations selected by cmp and write: compare-read, compare-write, access-read (victim inspection for writeback) and access-write (line fill).
- Outputs are registered, and completion is signalled by a one-cycle ack.

Parameters:
- DATA_W, 16, width of one data word.
- TAG_W, 5, tag width.
- WORD_W, 2, word-select width; the line holds 2**WORD_W words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  operation request, sampled each rising edge.
- word  input  WORD_W  word index within the line.
- cmp  input  1  1 = tag-compare operation; 0 = direct access to the victim way.
- write  input  1  1 = write; 0 = read.
- tag  input  TAG_W  request tag.
- data_in  input  DATA_W  write data.
- valid_in  input  1  valid bit stored on access-write.
- hit  output  1  selected way is valid and its tag equals tag (compare ops only).
- dirty  output  1  dirty bit of the selected way.
- tag_out  output  TAG_W  stored tag of the selected way.
- data_out  output  DATA_W  stored word [word] of the selected way (value after any write this op).
- valid  output  1  valid bit of the selected way.
- ack  output  1  one-cycle completion pulse.

Behaviour:
- Bit numbering of all vectors is MSB-first [0:N-1].
- Reset (rst_n=0, asynchronous):
  - all valid, dirty and LRU/victim state cleared;
  - hit, dirty, valid and ack = 0; tag_out and data_out = 0.
  - Data and tag arrays need not be reset.
- Reset asserted mid-operation aborts it: no array write, no ack.
- Operation sampled on a rising edge with enable=1. Results appear on the registered outputs at that same edge, and ack=1 for that cycle. ack drops after the next edge unless enable is still 1.
- Back-to-back enables produce one op and one ack per cycle.
- With enable=0, outputs hold their last values, except ack=0.
- Way match: way i matches when valid[i]=1 and tag_i==tag. At most one way can match; if both match, way 0 wins.
- Selected way: the matching way for compare ops; the victim way for access ops.
- Compare-read (cmp=1, write=0):
  - hit=1 on match; outputs reflect the matching way.
  - On miss: hit=0, and dirty, valid, tag_out and data_out reflect the victim way (so the controller can decide on writeback).
  - A hit updates LRU so the other way becomes the victim.
- Compare-write (cmp=1, write=1):
  - On hit: store data_in into word [word] of the matching way, set its dirty=1, update LRU; hit=1.
  - On miss: no array change; hit=0; outputs as for a compare-read miss.
- Access-read (cmp=0, write=0): outputs reflect the victim way; hit=0; no state change.
- Access-write (cmp=0, write=1):
  - Store data_in into word [word] of the victim way; set its tag=tag, valid=valid_in, dirty=0; hit=0.
  - The victim pointer does not advance, so a multi-word fill (4 consecutive access-writes) lands in the same way.
  - The victim advances only on a compare hit or, in round-robin mode, on a compare op that follows a fill.
- Output values for write ops are post-write values.

Optional Feature:
- Macro CACHE_SET_LRU_EN.
- Defined: one LRU bit per set. A compare hit on way i sets victim = other way. Access ops do not change it. Reset victim = way 0.
- Undefined: round-robin victim. The victim toggles on the first compare op following one or more access-writes; compare hits do not affect it. Reset victim = way 0.
- Port list is identical in both builds.

Test Plan:
- Reset: rst_n=0 then 1 -> hit=0, valid=0, dirty=0, ack=0. Compare-read of any tag -> hit=0, valid=0.
- Fill then hit: access-write tag=5'b11101, word=3, data_in=16'h0F0F, valid_in=1, then compare-read same tag/word -> ack pulses each op, hit=1, data_out=16'h0F0F, tag_out=5'b11101, valid=1, dirty=0.
- Fill with valid_in=0: compare-read of the same tag -> hit=0, valid=0.
- Compare-write hit: after the fill above, compare-write word=3, data_in=16'hA5A5 -> hit=1, dirty=1. A following compare-read returns 16'hA5A5.
- Compare miss with victim report: ways hold tags 5'h01 (dirty) and 5'h02. Compare-read tag 5'h07 -> hit=0, and tag_out/dirty show the victim way per replacement policy; access-read shows the same values.
- Enable low: hold enable=0 for 3 cycles after an op -> ack=0, outputs unchanged. Assert rst_n=0 between edges -> outputs clear immediately.
